pll_reconfig_seq: RTL and testbench

- Sequencer that retunes the system PLL at run time through the PLL reconfiguration IP's Avalon-MM management port, e.g. switching video or CPU clocks between PAL and NTSC profiles.
- Walks an external profile table of {register, value} entries and writes each entry to the reconfig IP.
- Issues START, then waits for the PLL to relock.
- Sits between the core's mode-select logic and the reconfig IP that drives reconfig_to_pll / reconfig_from_pll.

---
 rtl/pll_reconfig_seq.sv | 217 +++++++++++++++++++++
 tb/tb_pll_reconfig_seq.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reconfig_seq.sv
// pll_reconfig_seq
//   Retunes the system PLL at run time through the Avalon-MM management port
//   of the PLL reconfiguration IP. On a request it puts the IP in waitrequest
//   mode, walks one profile of an external {register, value} table, writes
//   each entry, issues START and then waits for the PLL to relock.
//
// Ports
//   clk, rst_n         : system clock, asynchronous active-low reset
//   req_valid/req_sel  : reconfiguration request and profile number
//   req_ready          : high only while idle
//   busy               : high from request accept until done/error
//   done               : one-cycle pulse on successful relock
//   error              : sticky lock-timeout flag, cleared by the next request
//   tbl_addr/tbl_data  : {sel, idx} address into a registered table
//                        (1-cycle latency); data = {reg[37:32], value[31:0]}
//   mgmt_*             : Avalon-MM write master towards the reconfig IP
//   pll_locked         : PLL lock, asynchronous to clk

module pll_reconfig_seq #(
  parameter int PROF_W       = 2,
  parameter int IDX_W        = 4,
  parameter int LOCK_STABLE  = 255,
  parameter int LOCK_TIMEOUT = 1048575
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  input  logic [PROF_W-1:0]       req_sel,
  output logic                    req_ready,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [PROF_W+IDX_W-1:0] tbl_addr,
  input  logic [37:0]             tbl_data,
  output logic [5:0]              mgmt_address,
  output logic [31:0]             mgmt_writedata,
  output logic                    mgmt_write,
  input  logic                    mgmt_waitrequest,
  input  logic                    pll_locked
);

  localparam int ST_W = $clog2(LOCK_STABLE) + 1;
  localparam int TO_W = $clog2(LOCK_TIMEOUT) + 1;

  localparam logic [ST_W-1:0]  ST_LIM   = ST_W'(LOCK_STABLE);
  localparam logic [ST_W-1:0]  ST_ONE   = ST_W'(1);
  localparam logic [TO_W-1:0]  TO_LIM   = TO_W'(LOCK_TIMEOUT);
  localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_MAX  = {IDX_W{1'b1}};
  localparam logic [5:0]       REG_MODE  = 6'd0;
  localparam logic [5:0]       REG_START = 6'd2;
  localparam logic [5:0]       REG_TERM  = 6'h3F;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_MODE      = 3'd1,
    S_FETCH     = 3'd2,
    S_WAITD     = 3'd3,
    S_WRITE     = 3'd4,
    S_START     = 3'd5,
    S_WAIT_LOCK = 3'd6
  } state_e;

  state_e                    state_q;
  logic [PROF_W-1:0]         sel_q;
  logic [IDX_W-1:0]          idx_q;
  logic [ST_W-1:0]           stable_q;
  logic [TO_W-1:0]           timeout_q;
  logic                      lock_meta_q;
  logic                      lock_sync_q;
  logic                      req_ready_q;
  logic                      busy_q;
  logic                      done_q;
  logic                      error_q;
  logic [PROF_W+IDX_W-1:0]   tbl_addr_q;
  logic [5:0]                mgmt_address_q;
  logic [31:0]               mgmt_writedata_q;
  logic                      mgmt_write_q;

  logic                      wr_done_s;
  logic [IDX_W-1:0]          idx_d;
  logic [ST_W-1:0]           stable_d;
  logic [TO_W-1:0]           timeout_d;

  // A write completes on the first cycle the strobe meets a low waitrequest.
  assign wr_done_s = mgmt_write_q & ~mgmt_waitrequest;
  assign idx_d     = idx_q + IDX_ONE;
  assign stable_d  = lock_sync_q ? (stable_q + ST_ONE) : {ST_W{1'b0}};
  // The timeout counts the current WAIT_LOCK cycle as already elapsed.
  assign timeout_d = timeout_q + TO_ONE;

  assign req_ready      = req_ready_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
  assign tbl_addr       = tbl_addr_q;
  assign mgmt_address   = mgmt_address_q;
  assign mgmt_writedata = mgmt_writedata_q;
  assign mgmt_write     = mgmt_write_q;

  // Two-flop synchroniser for the asynchronous PLL lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
    end else begin
      lock_meta_q <= pll_locked;
      lock_sync_q <= lock_meta_q;
    end
  end

  // Sequencer FSM with registered bus, table and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      sel_q            <= {PROF_W{1'b0}};
      idx_q            <= {IDX_W{1'b0}};
      stable_q         <= {ST_W{1'b0}};
      timeout_q        <= {TO_W{1'b0}};
      req_ready_q      <= 1'b1;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      error_q          <= 1'b0;
      tbl_addr_q       <= {(PROF_W+IDX_W){1'b0}};
      mgmt_address_q   <= 6'd0;
      mgmt_writedata_q <= 32'd0;
      mgmt_write_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            sel_q            <= req_sel;
            idx_q            <= {IDX_W{1'b0}};
            error_q          <= 1'b0;
            busy_q           <= 1'b1;
            req_ready_q      <= 1'b0;
            mgmt_address_q   <= REG_MODE;
            mgmt_writedata_q <= 32'd0;
            mgmt_write_q     <= 1'b1;
            state_q          <= S_MODE;
          end
        end
        S_MODE: begin
          if (wr_done_s) begin
            mgmt_write_q <= 1'b0;
            tbl_addr_q   <= {sel_q, idx_q};
            state_q      <= S_FETCH;
          end
        end
        S_FETCH: begin
          // tbl_addr is presented this cycle; data is valid in WAITD.
          state_q <= S_WAITD;
        end
        S_WAITD: begin
          mgmt_write_q <= 1'b1;
          if (tbl_data[37:32] == REG_TERM) begin
            mgmt_address_q   <= REG_START;
            mgmt_writedata_q <= 32'd0;
            state_q          <= S_START;
          end else begin
            mgmt_address_q   <= tbl_data[37:32];
            mgmt_writedata_q <= tbl_data[31:0];
            state_q          <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (wr_done_s) begin
            if (idx_q == IDX_MAX) begin
              // Table exhausted without a terminator: START back-to-back.
              mgmt_address_q   <= REG_START;
              mgmt_writedata_q <= 32'd0;
              state_q          <= S_START;
            end else begin
              mgmt_write_q <= 1'b0;
              idx_q        <= idx_d;
              tbl_addr_q   <= {sel_q, idx_d};
              state_q      <= S_FETCH;
            end
          end
        end
        S_START: begin
          // The IP stalls this write for the whole reconfiguration.
          if (wr_done_s) begin
            mgmt_write_q <= 1'b0;
            stable_q     <= {ST_W{1'b0}};
            timeout_q    <= {TO_W{1'b0}};
            state_q      <= S_WAIT_LOCK;
          end
        end
        S_WAIT_LOCK: begin
          timeout_q <= timeout_d;
          stable_q  <= stable_d;
          if (stable_q == ST_LIM) begin
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end else if (timeout_d == TO_LIM) begin
            error_q     <= 1'b1;
            busy_q      <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          mgmt_write_q <= 1'b0;
          busy_q       <= 1'b0;
          req_ready_q  <= 1'b1;
          state_q      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Testbench for pll_reconfig_seq: directed table vectors for reset/idle and
// the terminator-first profile, then hand-written multi-cycle sequences for
// timeout, stalls, lock glitch, unterminated table and reset mid-write.

module tb_pll_reconfig_seq;

  localparam int PROF_W       = 2;
  localparam int IDX_W        = 4;
  localparam int LOCK_STABLE  = 255;
  localparam int LOCK_TIMEOUT = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [1:0]  req_sel = 2'd0;
  logic        req_ready, busy, done, error;
  logic [5:0]  tbl_addr;
  logic [37:0] tbl_data;
  logic [5:0]  mgmt_address;
  logic [31:0] mgmt_writedata;
  logic        mgmt_write;
  logic        mgmt_waitrequest = 1'b0;
  logic        pll_locked = 1'b0;

  int total = 0;
  int bad = 0;

  pll_reconfig_seq #(
    .PROF_W(PROF_W), .IDX_W(IDX_W),
    .LOCK_STABLE(LOCK_STABLE), .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_sel(req_sel),
    .req_ready(req_ready), .busy(busy), .done(done), .error(error),
    .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .mgmt_address(mgmt_address), .mgmt_writedata(mgmt_writedata),
    .mgmt_write(mgmt_write), .mgmt_waitrequest(mgmt_waitrequest),
    .pll_locked(pll_locked)
  );

  always #5 clk = ~clk;

  // Registered profile table, one cycle read latency.
  logic [37:0] mem [0:63];
  always @(posedge clk) tbl_data <= mem[tbl_addr];

  // Reconfig IP model: random stalls, write log, stability check.
  int          stall_max = 0;
  int          stall_cnt = 0;
  int          stab_err = 0;
  logic        pend = 1'b0;
  logic [5:0]  p_addr = 6'd0;
  logic [31:0] p_data = 32'd0;
  logic [37:0] got_q [$];
  logic [37:0] exp_q [$];

  always @(negedge clk) begin
    if (!rst_n) begin
      mgmt_waitrequest = 1'b0;
      pend = 1'b0;
    end else begin
      if (pend && (mgmt_write !== 1'b1 || mgmt_address !== p_addr || mgmt_writedata !== p_data))
        stab_err++;
      if (mgmt_write && !pend) stall_cnt = int'($urandom_range(0, stall_max));
      if (mgmt_write && stall_cnt > 0) begin
        mgmt_waitrequest = 1'b1;
        stall_cnt--;
      end else begin
        mgmt_waitrequest = 1'b0;
      end
      pend = mgmt_write && mgmt_waitrequest;
      p_addr = mgmt_address;
      p_data = mgmt_writedata;
      if (mgmt_write && !mgmt_waitrequest) got_q.push_back({mgmt_address, mgmt_writedata});
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_writes(input string tag, input int base);
    check({tag, "_wr_count"}, 64'(got_q.size() - base), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i < got_q.size())
        check({tag, "_wr_seq"}, 64'(got_q[base + i]), 64'(exp_q[i]));
  endtask

  // One full reconfiguration: request, table walk, START, relock, done.
  task automatic run_profile(input logic [1:0] sel, input int smax, input int glitch_at,
                             input bit pulse, input string tag);
    int  base;
    int  sbase;
    int  cyc;
    int  exp_cyc;
    bit  seen;
    base = got_q.size();
    sbase = stab_err;
    stall_max = smax;
    pll_locked = 1'b0;
    req_sel = sel;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check({tag, "_accept"}, {61'd0, req_ready, busy, error}, {61'd0, 1'b0, 1'b1, 1'b0});
    seen = 1'b0;
    for (int k = 0; k < 3000 && !seen; k++) begin
      tick();
      if (pulse && k == 20) begin
        req_valid = 1'b1;
        req_sel = ~sel;
      end else begin
        req_valid = 1'b0;
      end
      if (got_q.size() > base && got_q[got_q.size() - 1][37:32] == 6'd2) seen = 1'b1;
    end
    req_valid = 1'b0;
    check({tag, "_start_seen"}, 64'(seen), 64'd1);
    if (!seen) return;
    // START completes at the next posedge, which also first samples the lock.
    pll_locked = 1'b1;
    cyc = 0;
    for (int k = 1; k <= 800 && cyc == 0; k++) begin
      tick();
      if (glitch_at > 0 && k == glitch_at) pll_locked = 1'b0;
      if (glitch_at > 0 && k == glitch_at + 1) pll_locked = 1'b1;
      if (done) cyc = k;
    end
    // 2 sync flops + LOCK_STABLE counts + compare cycle, seen one tick later.
    exp_cyc = (glitch_at > 0) ? (glitch_at + LOCK_STABLE + 4) : (LOCK_STABLE + 3);
    check({tag, "_done_cycle"}, 64'(cyc), 64'(exp_cyc));
    check({tag, "_done_status"}, {61'd0, busy, req_ready, error}, {61'd0, 1'b0, 1'b1, 1'b0});
    tick();
    check({tag, "_done_single"}, {62'd0, done, busy}, 64'd0);
    check_writes(tag, base);
    check({tag, "_stall_stable"}, 64'(stab_err - sbase), 64'd0);
  endtask

  typedef struct {
    logic       rv;
    logic [1:0] sel;
    logic       rdy;
    logic       bsy;
    logic       wr;
    logic [5:0] addr;
    logic       err;
  } vec_t;

  vec_t vt [16];

  initial begin
    int  base;
    int  cyc;
    bit  seen;

    for (int i = 0; i < 64; i++) mem[i] = {6'h3F, 32'h0};
    mem[16] = {6'd3, 32'h0001_0000};
    mem[17] = {6'd4, 32'h0000_0504};
    mem[18] = {6'd7, 32'h29E3_A1A3};
    for (int i = 0; i < 16; i++) mem[32 + i] = {6'(8 + i), 32'hA500_0000 + 32'(i)};
    mem[48] = {6'd5, 32'h1234_5678};

    // Idle hold then a terminator-first profile (0) with no stalls.
    for (int i = 0; i < 10; i++) vt[i] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0};
    vt[10] = '{1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0};
    vt[11] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 6'd0, 1'b0};
    vt[12] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0};
    vt[13] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0};
    vt[14] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 6'd2, 1'b0};
    vt[15] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 6'd2, 1'b0};

    tick();
    tick();
    check("reset_state", {req_ready, busy, done, error, tbl_addr, mgmt_address, mgmt_writedata, mgmt_write},
          {1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 32'd0, 1'b0});
    rst_n = 1'b1;

    base = got_q.size();
    for (int i = 0; i < 16; i++) begin
      tick();
      check($sformatf("vec%0d", i), {req_ready, busy, mgmt_write, mgmt_address, error},
            {vt[i].rdy, vt[i].bsy, vt[i].wr, vt[i].addr, vt[i].err});
      req_valid = vt[i].rv;
      req_sel = vt[i].sel;
    end
    req_valid = 1'b0;

    // Lock never arrives: error exactly LOCK_TIMEOUT cycles into WAIT_LOCK.
    cyc = 0;
    for (int k = 1; k <= 1200 && cyc == 0; k++) begin
      tick();
      if (error) cyc = k;
    end
    check("timeout_cycle", 64'(cyc), 64'(LOCK_TIMEOUT));
    check("timeout_status", {61'd0, busy, req_ready, done}, {61'd0, 1'b0, 1'b1, 1'b0});
    exp_q.delete();
    exp_q.push_back({6'd0, 32'd0});
    exp_q.push_back({6'd2, 32'd0});
    check_writes("term_first", base);

    // Profile 1, no stalls (also clears the sticky error on accept).
    exp_q.delete();
    exp_q.push_back({6'd0, 32'd0});
    exp_q.push_back({6'd3, 32'h0001_0000});
    exp_q.push_back({6'd4, 32'h0000_0504});
    exp_q.push_back({6'd7, 32'h29E3_A1A3});
    exp_q.push_back({6'd2, 32'd0});
    run_profile(2'd1, 0, 0, 1'b0, "p1");
    run_profile(2'd1, 5, 0, 1'b0, "p1_stall");
    run_profile(2'd1, 0, 202, 1'b0, "p1_glitch");

    // Unterminated 16-entry profile with a request pulsed while busy.
    exp_q.delete();
    exp_q.push_back({6'd0, 32'd0});
    for (int i = 0; i < 16; i++) exp_q.push_back({6'(8 + i), 32'hA500_0000 + 32'(i)});
    exp_q.push_back({6'd2, 32'd0});
    run_profile(2'd2, 3, 0, 1'b1, "p2_full");

    // Asynchronous reset while the profile-3 entry write is on the bus.
    stall_max = 2;
    req_sel = 2'd3;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      tick();
      if (mgmt_write && mgmt_address == 6'd5) seen = 1'b1;
    end
    check("rst_write_seen", 64'(seen), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {req_ready, busy, done, error, tbl_addr, mgmt_address, mgmt_writedata, mgmt_write},
          {1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 32'd0, 1'b0});
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("post_reset_idle", {60'd0, req_ready, busy, mgmt_write, error}, {60'd0, 1'b1, 1'b0, 1'b0, 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
